// File: rtl/shift_ctrl_if.sv
// Request/response bundle between the main control unit and the shift sequencer.
interface shift_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  shamt_sel;
    logic [31:0] rs_data;
    logic [15:0] instr;
    logic [31:0] mem_data;
    logic [31:0] src_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  shamt_out;

    modport master (
        output start, op, shamt_sel, rs_data, instr, mem_data, src_data,
        input  busy, done, result, shamt_out
    );

    modport slave (
        input  start, op, shamt_sel, rs_data, instr, mem_data, src_data,
        output busy, done, result, shamt_out
    );
endinterface

// File: rtl/shift_ctrl.sv
// Multicycle shift sequencer: latches operand and amount, shifts STEP bits per cycle, pulses done.
// Optional macro SHIFT_ZERO_SKIP_EN: a zero shift count goes straight from IDLE to DONE.
module shift_ctrl #(
    parameter int unsigned STEP = 1
) (
    input logic         clk,
    input logic         reset_n,
    shift_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [4:0] STEP_AMT = 5'(STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] sreg_q, sreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  sel_amt;
    logic [4:0]  step_k;
    logic [31:0] shifted;
    logic        unused_bits;

    // Only the 5-bit amount fields of the source buses are consumed.
    assign unused_bits = ^{bus.rs_data[31:5], bus.instr[15:11], bus.instr[5:0],
                           bus.mem_data[31:5]};

    always_comb begin
        sel_amt = 5'd0;
        unique case (bus.shamt_sel)
            2'b00:   sel_amt = bus.rs_data[4:0];
            2'b01:   sel_amt = bus.instr[10:6];
            2'b10:   sel_amt = bus.mem_data[4:0];
            default: sel_amt = 5'd0;
        endcase
    end

    assign step_k = (cnt_q < STEP_AMT) ? cnt_q : STEP_AMT;

    always_comb begin
        shifted = sreg_q;
        unique case (op_q)
            2'b00:   shifted = sreg_q << step_k;
            2'b01:   shifted = sreg_q >> step_k;
            2'b10:   shifted = $unsigned($signed(sreg_q) >>> step_k);
            default: shifted = sreg_q;
        endcase
    end

`ifdef SHIFT_ZERO_SKIP_EN
    logic zero_start;
    assign zero_start = (bus.op == 2'b11) || (sel_amt == 5'd0);
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d  = bus.src_data;
                    op_d    = bus.op;
                    shamt_d = sel_amt;
                    // Pass-through keeps the recorded amount but never shifts.
                    cnt_d   = (bus.op == 2'b11) ? 5'd0 : sel_amt;
`ifdef SHIFT_ZERO_SKIP_EN
                    state_d = zero_start ? DONE : SHIFT;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                end else begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q - step_k;
                    if (cnt_q == step_k) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= 32'd0;
            cnt_q   <= 5'd0;
            shamt_q <= 5'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
        end
    end

    assign bus.busy      = (state_q == SHIFT) || (state_q == DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = sreg_q;
    assign bus.shamt_out = shamt_q;
endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: STEP=1 and STEP=4 instances driven in lockstep, checked against a
// plain-arithmetic reference of the shift, amount selection and completion latency.
module tb_shift_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        d_start = 1'b0;
    logic [1:0]  d_op = 2'b00;
    logic [1:0]  d_sel = 2'b00;
    logic [31:0] d_rs = 32'd0;
    logic [15:0] d_instr = 16'd0;
    logic [31:0] d_mem = 32'd0;
    logic [31:0] d_src = 32'd0;

    shift_ctrl_if bus1 ();
    shift_ctrl_if bus4 ();

    assign bus1.start = d_start;   assign bus4.start = d_start;
    assign bus1.op = d_op;         assign bus4.op = d_op;
    assign bus1.shamt_sel = d_sel; assign bus4.shamt_sel = d_sel;
    assign bus1.rs_data = d_rs;    assign bus4.rs_data = d_rs;
    assign bus1.instr = d_instr;   assign bus4.instr = d_instr;
    assign bus1.mem_data = d_mem;  assign bus4.mem_data = d_mem;
    assign bus1.src_data = d_src;  assign bus4.src_data = d_src;

    shift_ctrl #(.STEP(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    shift_ctrl #(.STEP(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

    int total = 0;
    int bad = 0;

    int          obs_lat   [2];
    int          obs_pulse [2];
    logic [31:0] obs_res   [2];
    logic [31:0] obs_hold  [2];
    logic [4:0]  obs_amt   [2];
    logic        obs_bdone [2];
    logic        obs_bfirst[2];

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [4:0] ref_amt(input logic [1:0] sel, input logic [31:0] rs,
                                           input logic [15:0] ins, input logic [31:0] mem);
        case (sel)
            2'b00:   return rs[4:0];
            2'b01:   return ins[10:6];
            2'b10:   return mem[4:0];
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input int n,
                                              input logic [31:0] src);
        case (op)
            2'b00:   return src << n;
            2'b01:   return src >> n;
            2'b10:   return $unsigned($signed(src) >>> n);
            default: return src;
        endcase
    endfunction

    // Posedges after start is raised until done is first seen high.
    function automatic int ref_lat(input logic [1:0] op, input int n, input int step);
        int cnt;
        cnt = (op == 2'b11) ? 0 : n;
        if (cnt == 0) begin
`ifdef SHIFT_ZERO_SKIP_EN
            return 1;
`else
            return 2;
`endif
        end
        return (cnt + step - 1) / step + 1;
    endfunction

    task automatic run_op(input logic [1:0] op_v, input logic [1:0] sel_v,
                          input logic [31:0] rs_v, input logic [15:0] ins_v,
                          input logic [31:0] mem_v, input logic [31:0] src_v, input int poke);
        int last;
        for (int i = 0; i < 2; i++) begin
            obs_lat[i] = -1; obs_pulse[i] = 0; obs_res[i] = 32'd0; obs_hold[i] = 32'd0;
            obs_amt[i] = 5'd0; obs_bdone[i] = 1'b0; obs_bfirst[i] = 1'b0;
        end
        @(posedge clk); #1;
        d_op = op_v; d_sel = sel_v; d_rs = rs_v; d_instr = ins_v; d_mem = mem_v; d_src = src_v;
        d_start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                obs_bfirst[0] = bus1.busy;
                obs_bfirst[1] = bus4.busy;
            end
            // Sources change after acceptance; they must not affect the running op.
            d_start = (cyc == poke);
            d_op = 2'($urandom); d_sel = 2'($urandom); d_rs = $urandom;
            d_instr = 16'($urandom); d_mem = $urandom; d_src = $urandom;
            if (bus1.done) begin
                obs_pulse[0]++;
                if (obs_lat[0] < 0) begin
                    obs_lat[0] = cyc; obs_res[0] = bus1.result;
                    obs_amt[0] = bus1.shamt_out; obs_bdone[0] = bus1.busy;
                end
            end
            if (bus4.done) begin
                obs_pulse[1]++;
                if (obs_lat[1] < 0) begin
                    obs_lat[1] = cyc; obs_res[1] = bus4.result;
                    obs_amt[1] = bus4.shamt_out; obs_bdone[1] = bus4.busy;
                end
            end
            obs_hold[0] = bus1.result;
            obs_hold[1] = bus4.result;
            last = (obs_lat[0] > obs_lat[1]) ? obs_lat[0] : obs_lat[1];
            if (obs_lat[0] >= 0 && obs_lat[1] >= 0 && cyc >= last + 1) break;
        end
        d_start = 1'b0;
    endtask

    task automatic check_run(input string name, input logic [1:0] op_v, input int n,
                             input logic [31:0] src_v, input logic [31:0] exp_res);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_res[i] !== exp_res) begin
                bad++;
                $display("FAIL %s result step=%0d got=%h want=%h", name, step_of(i),
                         obs_res[i], exp_res);
            end
            total++;
            if (obs_lat[i] != ref_lat(op_v, n, step_of(i))) begin
                bad++;
                $display("FAIL %s latency step=%0d got=%0d want=%0d", name, step_of(i),
                         obs_lat[i], ref_lat(op_v, n, step_of(i)));
            end
            total++;
            if (obs_amt[i] !== 5'(n)) begin
                bad++;
                $display("FAIL %s shamt_out step=%0d got=%0d want=%0d", name, step_of(i),
                         obs_amt[i], n);
            end
            total++;
            if (obs_pulse[i] != 1 || obs_bdone[i] !== 1'b1 || obs_bfirst[i] !== 1'b1) begin
                bad++;
                $display("FAIL %s handshake step=%0d pulses=%0d busy_at_done=%b busy_first=%b want 1/1/1",
                         name, step_of(i), obs_pulse[i], obs_bdone[i], obs_bfirst[i]);
            end
            total++;
            if (obs_hold[i] !== exp_res) begin
                bad++;
                $display("FAIL %s hold step=%0d got=%h want=%h", name, step_of(i),
                         obs_hold[i], exp_res);
            end
        end
        if (src_v === 32'hx) $display("note: undefined source");
    endtask

    task automatic check_idle(input string name);
        total++;
        if ({bus1.busy, bus1.done, bus1.result, bus1.shamt_out} !== 39'd0) begin
            bad++;
            $display("FAIL %s step=1 busy=%b done=%b result=%h shamt=%0d want all 0", name,
                     bus1.busy, bus1.done, bus1.result, bus1.shamt_out);
        end
        total++;
        if ({bus4.busy, bus4.done, bus4.result, bus4.shamt_out} !== 39'd0) begin
            bad++;
            $display("FAIL %s step=4 busy=%b done=%b result=%h shamt=%0d want all 0", name,
                     bus4.busy, bus4.done, bus4.result, bus4.shamt_out);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
    endtask

    task automatic test_sll();
        run_op(2'b00, 2'b01, 32'd0, 16'h0100, 32'd0, 32'h0000_0001, 0);
        check_run("sll4", 2'b00, 4, 32'h1, 32'h0000_0010);
    endtask

    task automatic test_sra_srl();
        run_op(2'b10, 2'b00, 32'hFFFF_FFE3, 16'd0, 32'd0, 32'h8000_0000, 0);
        check_run("sra3", 2'b10, 3, 32'h8000_0000, 32'hF000_0000);
        run_op(2'b01, 2'b00, 32'hFFFF_FFE3, 16'd0, 32'd0, 32'h8000_0000, 0);
        check_run("srl3", 2'b01, 3, 32'h8000_0000, 32'h1000_0000);
    endtask

    task automatic test_srl_max();
        run_op(2'b01, 2'b10, 32'd0, 16'd0, 32'h0000_001F, 32'h8000_0000, 0);
        check_run("srl31", 2'b01, 31, 32'h8000_0000, 32'h0000_0001);
    endtask

    task automatic test_zero();
        run_op(2'b11, 2'b01, 32'd0, 16'h01C0, 32'd0, 32'h1234_5678, 0);
        check_run("pass", 2'b11, 7, 32'h1234_5678, 32'h1234_5678);
        run_op(2'b00, 2'b11, 32'h1F, 16'hFFFF, 32'h1F, 32'hCAFE_F00D, 0);
        check_run("sel_zero", 2'b00, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic test_contention();
        run_op(2'b00, 2'b00, 32'h0000_0014, 16'd0, 32'd0, 32'h0000_0003, 2);
        check_run("contention", 2'b00, 20, 32'h3, 32'h0030_0000);
    endtask

    task automatic test_abort();
        int seen_done;
        seen_done = 0;
        @(posedge clk); #1;
        d_op = 2'b01; d_sel = 2'b10; d_mem = 32'h1F; d_src = 32'h8000_0000; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus1.done || bus4.done) seen_done++;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_idle("abort_now");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus1.done || bus4.done) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d done cycles want=0", seen_done);
        end
        check_idle("abort_after");
        run_op(2'b00, 2'b00, 32'h5, 16'd0, 32'd0, 32'h0000_00FF, 0);
        check_run("after_abort", 2'b00, 5, 32'hFF, 32'h0000_1FE0);
    endtask

    task automatic test_random();
        logic [1:0]  op_v, sel_v;
        logic [31:0] rs_v, mem_v, src_v;
        logic [15:0] ins_v;
        int          n;
        for (int t = 0; t < 24; t++) begin
            op_v = 2'($urandom_range(0, 3));
            sel_v = 2'($urandom_range(0, 3));
            rs_v = $urandom; ins_v = 16'($urandom); mem_v = $urandom; src_v = $urandom;
            n = int'(ref_amt(sel_v, rs_v, ins_v, mem_v));
            run_op(op_v, sel_v, rs_v, ins_v, mem_v, src_v, (t % 3 == 0) ? 1 : 0);
            check_run("random", op_v, n, src_v, ref_shift(op_v, n, src_v));
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_srl_max();
        test_zero();
        test_contention();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
